// File: rtl/pipe_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// pipe_trace_monitor_if
//   Bundle between the CPU-side stimulus/observation point and the
//   pipe_trace_monitor. Carries the run request, the per-stage valid and
//   instruction buses, and the monitor's status and counters.
//
//   Parameters (must match the monitor instance):
//     NUM_STAGES  number of monitored pipeline stages
//     INSTR_W     instruction width per stage
//     CNT_W       width of the cycle and per-stage counters
//
//   Signals:
//     start        run request (driven by master)
//     stage_valid  per-stage instruction valid (driven by master)
//     stage_instr  per-stage instruction, stage i at [i*INSTR_W +: INSTR_W]
//     running      monitor is counting (driven by slave)
//     done         run finished (driven by slave)
//     timeout      run ended on the cycle budget (driven by slave)
//     hang         run ended on last-stage stall detection (driven by slave)
//     cycle_count  cycles spent in the current/last run (driven by slave)
//     stage_count  per-stage valid counts, stage i at [i*CNT_W +: CNT_W]
//
//   Modports:
//     master  stimulus side (bench / CPU wrapper)
//     slave   the monitor
// ---------------------------------------------------------------------------
interface pipe_trace_monitor_if #(
  parameter int NUM_STAGES = 2,
  parameter int INSTR_W    = 32,
  parameter int CNT_W      = 32
);
  logic                          start;
  logic [NUM_STAGES-1:0]         stage_valid;
  logic [NUM_STAGES*INSTR_W-1:0] stage_instr;
  logic                          running;
  logic                          done;
  logic                          timeout;
  logic                          hang;
  logic [CNT_W-1:0]              cycle_count;
  logic [NUM_STAGES*CNT_W-1:0]   stage_count;

  modport master (
    output start, stage_valid, stage_instr,
    input  running, done, timeout, hang, cycle_count, stage_count
  );

  modport slave (
    input  start, stage_valid, stage_instr,
    output running, done, timeout, hang, cycle_count, stage_count
  );
endinterface

// File: rtl/pipe_trace_monitor.sv
// ---------------------------------------------------------------------------
// pipe_trace_monitor
//   Cycle-accounting and run-control monitor that sits beside the CPU in the
//   simulation top. While a run is active it counts cycles and per-stage
//   valid instructions, and it ends the run either when a cycle budget is
//   used up or when the last monitored stage stays frozen on the same valid
//   instruction for STALL_LIMIT consecutive samples. All outputs come from
//   registers; there is no combinational input-to-output path.
//
//   Parameters:
//     NUM_STAGES   monitored stages (1..8); stage 0 = fetch, NUM_STAGES-1 = last
//     INSTR_W      instruction width per stage
//     CNT_W        width of cycle and per-stage counters (saturating)
//     MAX_CYCLES   cycle budget per run, 0 = unlimited
//     STALL_LIMIT  consecutive frozen last-stage samples that flag a hang (>=1)
//
//   Ports:
//     clk   clock, all logic on the rising edge
//     rst   synchronous active-low reset, overrides start
//     bus   pipe_trace_monitor_if.slave: start, stage_valid, stage_instr in;
//           running, done, timeout, hang, cycle_count, stage_count out
//
//   Optional feature:
//     PIPE_TRACE_MONITOR_TRACE_EN  when defined, compiles simulation-only
//     $display tracing of every counted cycle and of the end-of-run reason.
//     When undefined, no display statements exist and behaviour is identical.
// ---------------------------------------------------------------------------
// State table
//   state  | meaning
//   S_IDLE | after reset; counters hold, waits for start
//   S_RUN  | counting cycles and stage valids, watching for budget/hang
//   S_DONE | run ended; counters and flags hold, start begins a new run
// ---------------------------------------------------------------------------
module pipe_trace_monitor #(
  parameter int NUM_STAGES  = 2,
  parameter int INSTR_W     = 32,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 20,
  parameter int STALL_LIMIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  pipe_trace_monitor_if.slave bus
);

  localparam int L  = NUM_STAGES - 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_ALL1       = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
  localparam logic [SW-1:0]    STALL_LIM_V    = SW'(STALL_LIMIT);
  localparam logic [SW-1:0]    STALL_ONE      = SW'(1);
  localparam logic [63:0]      MAX_CYCLES_EXT = 64'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic                           w_start_run;

  logic [CNT_W-1:0]               r_cycle_cnt;
  logic [CNT_W-1:0]               w_cycle_next;
  logic [NUM_STAGES-1:0][CNT_W-1:0] r_stage_cnt;
  logic [NUM_STAGES-1:0][CNT_W-1:0] w_stage_next;

  logic [SW-1:0]                  r_stall_cnt;
  logic [SW-1:0]                  w_stall_next;
  logic                           r_prev_valid;
  logic [INSTR_W-1:0]             r_prev_instr;

  logic                           r_timeout;
  logic                           r_hang;

  logic                           w_last_valid;
  logic [INSTR_W-1:0]             w_last_instr;
  logic                           w_frozen;
  logic                           w_budget_hit;
  logic                           w_hang_hit;

  // Only the last stage's instruction feeds the logic; the other stages are
  // observed by the optional trace only.
  logic                           w_unused_instr;
  assign w_unused_instr = ^bus.stage_instr;

  // ---------------------------------------------------------------------
  // Datapath: saturating counters and last-stage freeze tracking
  // ---------------------------------------------------------------------
  always_comb begin
    w_last_valid = bus.stage_valid[L];
    w_last_instr = bus.stage_instr[L*INSTR_W +: INSTR_W];

    w_cycle_next = (r_cycle_cnt == CNT_ALL1) ? r_cycle_cnt : r_cycle_cnt + CNT_ONE;

    w_stage_next = r_stage_cnt;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (bus.stage_valid[i] && (r_stage_cnt[i] != CNT_ALL1)) begin
        w_stage_next[i] = r_stage_cnt[i] + CNT_ONE;
      end
    end

    // A frozen sample needs a valid previous sample; r_prev_valid is cleared
    // on run entry so the first cycle of a run never counts.
    w_frozen = w_last_valid && r_prev_valid && (w_last_instr == r_prev_instr);

    if (!w_frozen) begin
      w_stall_next = '0;
    end else if (r_stall_cnt == STALL_LIM_V) begin
      w_stall_next = r_stall_cnt;
    end else begin
      w_stall_next = r_stall_cnt + STALL_ONE;
    end

    // Compared at 64 bits so a budget wider than the counter never matches
    // a truncated value.
    w_budget_hit = (MAX_CYCLES != 0) && (64'(w_cycle_next) == MAX_CYCLES_EXT);
    w_hang_hit   = (w_stall_next == STALL_LIM_V);
  end

  // ---------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start_run  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
          w_start_run  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_budget_hit || w_hang_hit) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
          w_start_run  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counter / flag registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst || w_start_run) begin
      r_cycle_cnt  <= '0;
      r_stage_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_prev_valid <= 1'b0;
      r_prev_instr <= '0;
      r_timeout    <= 1'b0;
      r_hang       <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cycle_cnt  <= w_cycle_next;
      r_stage_cnt  <= w_stage_next;
      r_stall_cnt  <= w_stall_next;
      r_prev_valid <= w_last_valid;
      r_prev_instr <= w_last_instr;
      // Both hits can land on the same edge; each flag records its own cause.
      r_timeout    <= w_budget_hit;
      r_hang       <= w_hang_hit;
    end
  end

  assign bus.running     = (r_state == S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.timeout     = r_timeout;
  assign bus.hang        = r_hang;
  assign bus.cycle_count = r_cycle_cnt;
  assign bus.stage_count = r_stage_cnt;

  // ---------------------------------------------------------------------
  // Optional simulation trace
  // ---------------------------------------------------------------------
`ifdef PIPE_TRACE_MONITOR_TRACE_EN
  always @(posedge clk) begin
    if (rst && (r_state == S_RUN)) begin
      $display("[pipe_trace_monitor] cycle %0d", w_cycle_next);
      for (int i = 0; i < NUM_STAGES; i++) begin
        $display("[pipe_trace_monitor]   stage %0d valid %b instr %h",
                 i, bus.stage_valid[i], bus.stage_instr[i*INSTR_W +: INSTR_W]);
      end
      if (w_budget_hit || w_hang_hit) begin
        if (w_budget_hit && w_hang_hit) begin
          $display("[pipe_trace_monitor] run end: BOTH");
        end else if (w_budget_hit) begin
          $display("[pipe_trace_monitor] run end: TIMEOUT");
        end else begin
          $display("[pipe_trace_monitor] run end: HANG");
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
          $display("[pipe_trace_monitor]   stage %0d count %0d", i, w_stage_next[i]);
        end
      end
    end
  end
`else
  // Trace disabled: no display statements are compiled.
`endif

endmodule

// File: tb/tb_pipe_trace_monitor.sv
module tb_pipe_trace_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a: default build (budget 20, stall limit 8)
  // dut_b: 4-bit counters, unlimited budget
  // dut_c: budget 10
  pipe_trace_monitor_if #(.NUM_STAGES(2), .INSTR_W(32), .CNT_W(32)) ifa ();
  pipe_trace_monitor_if #(.NUM_STAGES(2), .INSTR_W(32), .CNT_W(4))  ifb ();
  pipe_trace_monitor_if #(.NUM_STAGES(2), .INSTR_W(32), .CNT_W(32)) ifc ();

  pipe_trace_monitor #(.NUM_STAGES(2), .INSTR_W(32), .CNT_W(32), .MAX_CYCLES(20), .STALL_LIMIT(8))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipe_trace_monitor #(.NUM_STAGES(2), .INSTR_W(32), .CNT_W(4), .MAX_CYCLES(0), .STALL_LIMIT(8))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  pipe_trace_monitor #(.NUM_STAGES(2), .INSTR_W(32), .CNT_W(32), .MAX_CYCLES(10), .STALL_LIMIT(8))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Stimulus for one run, indexed by run cycle k = 1..N
  logic [1:0]  sv  [0:63];
  logic [31:0] si0 [0:63];
  logic [31:0] si1 [0:63];

  // Hang at cycle k: samples k-lim..k of the last stage are all valid and
  // identical (lim frozen samples need lim+1 matching samples inside the run).
  function automatic bit window_frozen(input int k, input int lim);
    if (k - lim < 1) return 1'b0;
    for (int j = k - lim; j <= k; j++) begin
      if (!sv[j][1] || (si1[j] !== si1[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int expected_end(input int n, input int maxc, input int lim);
    for (int k = 1; k <= n; k++) begin
      if ((maxc != 0 && k == maxc) || window_frozen(k, lim)) return k;
    end
    return 0;
  endfunction

  function automatic longint exp_stage(input int s, input int e, input longint cmax);
    longint c = 0;
    for (int j = 1; j <= e; j++) if (sv[j][s]) c++;
    return (c > cmax) ? cmax : c;
  endfunction

  task automatic drive_a(input int k);
    ifa.stage_valid = sv[k];
    ifa.stage_instr = {si1[k], si0[k]};
  endtask

  task automatic drive_c(input int k);
    ifc.stage_valid = sv[k];
    ifc.stage_instr = {si1[k], si0[k]};
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    ifa.start = 1'b1; ifb.start = 1'b1; ifc.start = 1'b1;
    ifa.stage_valid = 2'b11; ifb.stage_valid = 2'b11; ifc.stage_valid = 2'b11;
    ifa.stage_instr = {$urandom, $urandom};
    ifb.stage_instr = {$urandom, $urandom};
    ifc.stage_instr = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ifa.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", ifa.running); end
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", ifa.done); end
    checks++; if (ifa.timeout !== 1'b0 || ifa.hang !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", ifa.timeout, ifa.hang); end
    checks++; if (ifa.cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", ifa.cycle_count); end
    checks++; if (ifa.stage_count !== 64'd0) begin errors++; $display("FAIL reset_stage got %h exp 0", ifa.stage_count); end
    checks++; if (ifb.running !== 1'b0 || ifc.running !== 1'b0) begin errors++; $display("FAIL reset_running_bc got %b%b exp 00", ifb.running, ifc.running); end
    ifb.start = 1'b0; ifc.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ifa.running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", ifa.running); end
    checks++; if (ifa.cycle_count !== 32'd0) begin errors++; $display("FAIL start_cycle got %0d exp 0", ifa.cycle_count); end
    checks++; if (ifb.running !== 1'b0) begin errors++; $display("FAIL idle_b_running got %b exp 0", ifb.running); end
    ifa.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (ifa.running !== 1'b0 || ifa.cycle_count !== 32'd0) begin errors++; $display("FAIL midrun_reset_a got running %b cycle %0d exp 0 0", ifa.running, ifa.cycle_count); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_budget();
    for (int k = 1; k <= 20; k++) begin
      sv[k] = 2'b11; si0[k] = 32'h1000 + 32'(k); si1[k] = 32'h2000 + 32'(k);
    end
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      drive_a(k);
      @(negedge clk);
      checks++; if (ifa.cycle_count !== 32'(k)) begin errors++; $display("FAIL budget_cycle k=%0d got %0d exp %0d", k, ifa.cycle_count, k); end
      checks++; if (ifa.done !== (k == 20)) begin errors++; $display("FAIL budget_done k=%0d got %b exp %b", k, ifa.done, (k == 20)); end
      checks++; if (ifa.running !== (k < 20)) begin errors++; $display("FAIL budget_running k=%0d got %b exp %b", k, ifa.running, (k < 20)); end
    end
    checks++; if (ifa.stage_count !== {32'd20, 32'd20}) begin errors++; $display("FAIL budget_stage got %h exp {20,20}", ifa.stage_count); end
    checks++; if (ifa.timeout !== 1'b1 || ifa.hang !== 1'b0) begin errors++; $display("FAIL budget_flags got t%b h%b exp t1 h0", ifa.timeout, ifa.hang); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hang();
    for (int k = 1; k <= 20; k++) begin
      sv[k] = {1'b1, 1'($urandom_range(0, 1))}; si0[k] = $urandom; si1[k] = 32'h0000_0013;
    end
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    checks++; if (ifa.done !== 1'b0 || ifa.running !== 1'b1) begin errors++; $display("FAIL hang_restart got done %b running %b exp 0 1", ifa.done, ifa.running); end
    checks++; if (ifa.timeout !== 1'b0 || ifa.cycle_count !== 32'd0) begin errors++; $display("FAIL hang_clear got t%b cycle %0d exp 0 0", ifa.timeout, ifa.cycle_count); end
    for (int k = 1; k <= 9; k++) begin
      drive_a(k);
      @(negedge clk);
      checks++; if (ifa.done !== (k == 9)) begin errors++; $display("FAIL hang_done k=%0d got %b exp %b", k, ifa.done, (k == 9)); end
    end
    checks++; if (ifa.cycle_count !== 32'd9) begin errors++; $display("FAIL hang_cycle got %0d exp 9", ifa.cycle_count); end
    checks++; if (ifa.hang !== 1'b1 || ifa.timeout !== 1'b0) begin errors++; $display("FAIL hang_flags got h%b t%b exp h1 t0", ifa.hang, ifa.timeout); end
    checks++; if (ifa.stage_count[63:32] !== 32'd9) begin errors++; $display("FAIL hang_stage1 got %0d exp 9", ifa.stage_count[63:32]); end
    checks++; if (ifa.stage_count[31:0] !== 32'(exp_stage(0, 9, 64'hFFFF_FFFF))) begin errors++; $display("FAIL hang_stage0 got %0d exp %0d", ifa.stage_count[31:0], exp_stage(0, 9, 64'hFFFF_FFFF)); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_partial_valid();
    for (int k = 1; k <= 10; k++) begin
      sv[k] = {(k % 5 != 0), (k % 2 == 1)}; si0[k] = $urandom; si1[k] = 32'h0000_0013;
    end
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive_c(k);
      @(negedge clk);
      checks++; if (ifc.done !== (k == 10)) begin errors++; $display("FAIL partial_done k=%0d got %b exp %b", k, ifc.done, (k == 10)); end
    end
    checks++; if (ifc.stage_count[31:0] !== 32'd5) begin errors++; $display("FAIL partial_stage0 got %0d exp 5", ifc.stage_count[31:0]); end
    checks++; if (ifc.stage_count[63:32] !== 32'd8) begin errors++; $display("FAIL partial_stage1 got %0d exp 8", ifc.stage_count[63:32]); end
    checks++; if (ifc.timeout !== 1'b1 || ifc.hang !== 1'b0) begin errors++; $display("FAIL partial_flags got t%b h%b exp t1 h0", ifc.timeout, ifc.hang); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_saturation();
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      ifb.stage_valid = 2'b11;
      ifb.stage_instr = {32'h300 + 32'(k), 32'h400 + 32'(k)};
      @(negedge clk);
      checks++; if (ifb.cycle_count !== 4'((k > 15) ? 15 : k)) begin errors++; $display("FAIL sat_cycle k=%0d got %0d exp %0d", k, ifb.cycle_count, (k > 15) ? 15 : k); end
    end
    checks++; if (ifb.stage_count !== 8'hFF) begin errors++; $display("FAIL sat_stage got %h exp ff", ifb.stage_count); end
    checks++; if (ifb.running !== 1'b1 || ifb.done !== 1'b0) begin errors++; $display("FAIL sat_state got running %b done %b exp 1 0", ifb.running, ifb.done); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (ifb.cycle_count !== 4'd0 || ifb.stage_count !== 8'd0) begin errors++; $display("FAIL sat_reset got cycle %0d stage %h exp 0 0", ifb.cycle_count, ifb.stage_count); end
    checks++; if (ifb.running !== 1'b0 || ifb.done !== 1'b0) begin errors++; $display("FAIL sat_reset_state got running %b done %b exp 0 0", ifb.running, ifb.done); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_random();
    int e;
    bit exp_h;
    for (int run = 0; run < 8; run++) begin
      for (int k = 1; k <= 40; k++) begin
        sv[k]  = {($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1))};
        si0[k] = $urandom;
        si1[k] = (k > 1 && $urandom_range(0, 99) < 85) ? si1[k-1] : $urandom;
      end
      e = expected_end(40, 20, 8);
      exp_h = window_frozen(e, 8);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      checks++; if (ifa.running !== 1'b1) begin errors++; $display("FAIL rand_start run=%0d got %b exp 1", run, ifa.running); end
      for (int k = 1; k <= e; k++) begin
        drive_a(k);
        @(negedge clk);
        checks++; if (ifa.done !== (k == e)) begin errors++; $display("FAIL rand_done run=%0d k=%0d got %b exp %b", run, k, ifa.done, (k == e)); end
        checks++; if (ifa.cycle_count !== 32'(k)) begin errors++; $display("FAIL rand_cycle run=%0d k=%0d got %0d exp %0d", run, k, ifa.cycle_count, k); end
      end
      checks++; if (ifa.timeout !== (e == 20) || ifa.hang !== exp_h) begin errors++; $display("FAIL rand_flags run=%0d got t%b h%b exp t%b h%b", run, ifa.timeout, ifa.hang, (e == 20), exp_h); end
      checks++; if (ifa.stage_count[31:0] !== 32'(exp_stage(0, e, 64'hFFFF_FFFF))) begin errors++; $display("FAIL rand_stage0 run=%0d got %0d exp %0d", run, ifa.stage_count[31:0], exp_stage(0, e, 64'hFFFF_FFFF)); end
      checks++; if (ifa.stage_count[63:32] !== 32'(exp_stage(1, e, 64'hFFFF_FFFF))) begin errors++; $display("FAIL rand_stage1 run=%0d got %0d exp %0d", run, ifa.stage_count[63:32], exp_stage(1, e, 64'hFFFF_FFFF)); end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    for (int k = 1; k <= 21; k++) begin
      sv[k] = 2'($urandom_range(0, 3)); si0[k] = $urandom; si1[k] = 32'h5000 + 32'(k);
    end
    ifa.start = 1'b1;
    @(negedge clk);
    checks++; if (ifa.running !== 1'b1 || ifa.done !== 1'b0) begin errors++; $display("FAIL b2b_restart got running %b done %b exp 1 0", ifa.running, ifa.done); end
    for (int k = 1; k <= 20; k++) begin
      drive_a(k);
      @(negedge clk);
      checks++; if (ifa.cycle_count !== 32'(k)) begin errors++; $display("FAIL b2b_cycle k=%0d got %0d exp %0d", k, ifa.cycle_count, k); end
    end
    checks++; if (ifa.done !== 1'b1 || ifa.timeout !== 1'b1) begin errors++; $display("FAIL b2b_done got done %b t%b exp 1 1", ifa.done, ifa.timeout); end
    checks++; if (ifa.stage_count[31:0] !== 32'(exp_stage(0, 20, 64'hFFFF_FFFF))) begin errors++; $display("FAIL b2b_stage0 got %0d exp %0d", ifa.stage_count[31:0], exp_stage(0, 20, 64'hFFFF_FFFF)); end
    drive_a(21);
    @(negedge clk);
    checks++; if (ifa.done !== 1'b0 || ifa.running !== 1'b1) begin errors++; $display("FAIL b2b_rerun got done %b running %b exp 0 1", ifa.done, ifa.running); end
    checks++; if (ifa.cycle_count !== 32'd0 || ifa.stage_count !== 64'd0 || ifa.timeout !== 1'b0) begin errors++; $display("FAIL b2b_clear got cycle %0d stage %h t%b exp 0 0 0", ifa.cycle_count, ifa.stage_count, ifa.timeout); end
    ifa.start = 1'b0;
    @(negedge clk);
    checks++; if (ifa.cycle_count !== 32'd1) begin errors++; $display("FAIL b2b_first got %0d exp 1", ifa.cycle_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_budget();
    test_hang();
    test_partial_valid();
    test_saturation();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_trace_monitor.md
# pipe_trace_monitor

Cycle-accounting and run-control monitor sitting beside the CPU in the simulation top. It replaces ad-hoc bench counters and fixed `#delay` finishes. It counts cycles and per-stage valid instructions for a parametrised number of pipeline stages. It ends a run on a cycle budget or on a detected pipeline hang, and reports which condition fired.

## Interface
Parameters:
- NUM_STAGES, 2, number of monitored pipeline stages (1..8); stage 0 = fetch, stage NUM_STAGES-1 = last monitored stage
- INSTR_W, 32, instruction width per stage
- CNT_W, 32, width of cycle and per-stage counters
- MAX_CYCLES, 20, cycle budget per run; 0 = unlimited
- STALL_LIMIT, 8, consecutive frozen cycles on last stage that flag a hang (≥1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  begin a run (sampled in IDLE and DONE)
- stage_valid  in  NUM_STAGES  per-stage instruction-valid
- stage_instr  in  NUM_STAGES*INSTR_W  per-stage instruction; stage i at [i*INSTR_W +: INSTR_W]
- running  out  1  high in RUN
- done  out  1  high in DONE
- timeout  out  1  run ended on MAX_CYCLES (valid while done)
- hang  out  1  run ended on stall detection (valid while done)
- cycle_count  out  CNT_W  cycles spent in RUN this run
- stage_count  out  NUM_STAGES*CNT_W  per-stage count of valid cycles this run; stage i at [i*CNT_W +: CNT_W]

## Operation
- FSM states:
  - IDLE → RUN on start. Entering RUN clears all counters, timeout, hang, and stall tracking.
  - RUN → DONE when the budget or hang condition fires.
  - DONE → RUN on start, with the same clearing.
  - DONE otherwise holds.
- In RUN, each cycle:
  - cycle_count +1.
  - stage_count[i] +1 when stage_valid[i].
  - All counters saturate at 2^CNT_W−1; no wrap.
- Budget: when MAX_CYCLES≠0 and the incremented cycle_count equals MAX_CYCLES → DONE, timeout=1.
- Hang detection on last stage L=NUM_STAGES−1:
  - stall_cnt increments when stage_valid[L]=1 and stage_instr[L] equals its value from the previous cycle, with the previous cycle also valid.
  - Otherwise stall_cnt resets to 0.
  - stall_cnt reaching STALL_LIMIT → DONE, hang=1.
  - The first RUN cycle has no previous sample and never counts as a stall.
- Simultaneous budget and hang in the same cycle: both timeout and hang set; DONE.
- In DONE and IDLE, counters and flags hold their values.
- rst low at any clock edge, including mid-run:
  - state=IDLE.
  - All outputs 0: running, done, timeout, hang, cycle_count, all stage_count.
  - stall tracking cleared.
  - rst overrides start.

## Timing
- Outputs are registered; no combinational input→output path.
- start sampled high at edge N: running=1 after N. The first counted cycle is sampled at edge N+1.
- cycle_count after edge k of RUN equals k.
- Budget end: cycle_count=MAX_CYCLES, and done=1 after the same edge; running=0 at that edge.
- Hang end: done=1 after the edge at which the STALL_LIMIT-th consecutive frozen sample is taken.
- start held high in RUN is ignored.
- start high in DONE restarts the run next edge, with done falling on that edge.

## Configuration
- PIPE_TRACE_MONITOR_TRACE_EN defined:
  - Each RUN cycle, simulation-only `$display` prints cycle_count and, per stage, valid bit and instruction in hex.
  - On entering DONE, prints the end reason (TIMEOUT/HANG/BOTH) and final stage_count values.
- Undefined: no display statements compiled; logic and port behaviour identical.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 → all outputs 0, state IDLE; release, start pulse → running=1 next edge.
- Budget: MAX_CYCLES=20, stage_valid=2'b11, instr changing every cycle → done=1 with cycle_count=20, stage_count={20,20}, timeout=1, hang=0.
- Hang: STALL_LIMIT=8, last stage valid with constant 32'h00000013 from run cycle 1 → hang=1, timeout=0, done after cycle_count=9.
- Partial valid: stage_valid[0] toggling 1,0,1,0…, MAX_CYCLES=10 → stage_count[0]=5; an invalid cycle between equal instructions resets stall count, so no hang.
- Saturation/restart: CNT_W=4, MAX_CYCLES=0, changing instr → cycle_count sticks at 15. Reset mid-run with rst=0 → all counters 0. Restart from DONE via start → counters cleared and cycle_count=1 after first RUN edge.
